egress_scheduler: RTL and testbench
===================================

Name: egress_scheduler

Overview:
- Downstream consumer of the four-port FIFO interconnect. It drains the output FIFOs fifo4..fifo7 into one serial 10-bit stream with a valid/ready handshake.
- It pops one FIFO per cycle at most, using round-robin arbitration over the non-empty FIFOs.
- It buffers returned words in a small output queue so that downstream backpressure never causes data loss.
- It keeps a per-port forwarded-word count.

Parameters:
- DATA_W, 10, word width, matching the interconnect FIFO words.
- BUF_DEPTH, 4, output queue entries. Must be >= 3 to sustain one word per cycle.
- CNT_W, 8, width of each per-port counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- fifo4_out, fifo5_out, fifo6_out, fifo7_out  in  DATA_W each  registered read data of FIFO 4..7. Valid the cycle after the matching pop.
- empty4, empty5, empty6, empty7  in  1 each  FIFO empty flag. Reflects any pop from the previous edge.
- pop4, pop5, pop6, pop7  out  1 each  pop request; at most one is high per cycle.
- enable  in  1  1 = schedule new pops; 0 = stop popping and drain.
- data_out  out  DATA_W  head word of the output queue.
- src_out  out  2  source port of the head word (0 = fifo4 ... 3 = fifo7).
- valid_out  out  1  output queue non-empty.
- ready_in  in  1  downstream accepts; a transfer occurs when valid_out && ready_in.
- cnt_sel  in  2  selects a port counter.
- cnt_out  out  CNT_W  count for cnt_sel (combinational mux of the counter registers).
- idle  out  1  1 when in state IDLE.

Behaviour:

Reset (reset=0, asynchronous):
- pop4..7 = 0, valid_out = 0, data_out = 0, src_out = 0.
- Queue occupancy = 0, inflight = 0, all counters = 0.
- RR pointer = 3, so port 0 has first priority. State = IDLE, idle = 1.
- Reset asserted mid-operation discards queued and in-flight words. The word returned after a pop that was cut off by reset is ignored.

State machine:
- IDLE: no pops. Moves to ACTIVE when enable=1.
- ACTIVE: pops allowed. Moves to DRAIN when enable=0.
- DRAIN: no new pops; queue keeps emptying through the handshake. Moves to IDLE when inflight=0 and occupancy=0. Returns to ACTIVE if enable=1 again.
- idle = (state==IDLE).

Pop rule (cycle t):
- Pop only in ACTIVE, only if at least one emptyN=0, and only if occ_t + inflight_t < BUF_DEPTH.
- Dequeue in the same cycle is ignored (conservative credit).
- Grant the first non-empty port scanning from ptr+1 modulo 4. Drive that port's pop combinationally from the registered state and the empty flags.
- On a grant, update ptr to the granted port, set inflight=1 and record src. If no pop is issued, inflight=0.

Capture:
- In cycle t+1, fifoN_out of the recorded src is written into the queue tail at the end of t+1.
- valid_out rises in cycle t+2. Pop-to-valid_out latency is 2 cycles.
- The counter of that src increments on capture and wraps from 2^CNT_W-1 to 0.

Queue:
- Circular buffer with head and tail pointers wrapping at BUF_DEPTH.
- Simultaneous enqueue and dequeue leaves occupancy unchanged.
- data_out and src_out hold stable while valid_out=1 and ready_in=0.
- Overflow is impossible by the credit rule. A bench assertion checks occupancy <= BUF_DEPTH.

Never pop a FIFO whose emptyN=1. With a single non-empty port, that port is popped on consecutive cycles.

Decomposition:
- Shared package holds: DATA_W, port count 4, the state encoding (IDLE=2'd0, ACTIVE=2'd1, DRAIN=2'd2), and the src port codes.
- One sub-module: egress_queue. It is the BUF_DEPTH x (DATA_W+2) circular buffer with occupancy, valid/ready head and enqueue port.
- Arbitration, credit and the state machine stay in egress_scheduler.

Test Plan:
1. Reset, then enable=1, ready_in=1, only empty4=0, FIFO holding 10'h101, 10'h102, 10'h103:
   - pop4 high 3 consecutive cycles.
   - valid_out rises 2 cycles after the first pop.
   - data_out sequence 101, 102, 103 with src_out=0.
   - cnt_sel=0 gives cnt_out=3.
2. All four FIFOs hold 2 words each, ready_in=1:
   - Grant order 4,5,6,7,4,5,6,7.
   - src_out sequence 0,1,2,3,0,1,2,3.
   - 8 words forwarded in 8 consecutive valid cycles.
3. ready_in=0 with FIFOs non-empty:
   - Exactly BUF_DEPTH=4 pops are issued, then pops stop.
   - data_out stays on the first word.
   - Raising ready_in resumes flow with no lost or duplicated word.
4. enable dropped while 3 words are queued and 1 is in flight:
   - No further pops.
   - 4 words delivered, then idle=1.
   - enable=1 resumes pops next cycle.
5. reset pulsed low mid-stream with the queue holding 2 words:
   - Outputs cleared immediately (valid_out=0, all pops 0, counters 0, idle=1).
   - After release, first grant goes to port 0 (fifo4).
6. 256 words from fifo6:
   - cnt_sel=2 gives cnt_out=0 after wrap.
   - At 257 words, cnt_out=1.

Source files
------------

// File: rtl/egress_scheduler_pkg.sv
// Shared definitions for the egress scheduler: word width, port count,
// state encoding and source port codes.
package egress_scheduler_pkg;

  localparam int DATA_W    = 10;
  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_FIFO4 = 2'd0,
    SRC_FIFO5 = 2'd1,
    SRC_FIFO6 = 2'd2,
    SRC_FIFO7 = 2'd3
  } src_t;

endpackage

// File: rtl/egress_scheduler_if.sv
// Bus between the interconnect output FIFOs 4..7, the scheduler and the
// downstream consumer. The scheduler sits on the slave modport.
interface egress_scheduler_if;
  import egress_scheduler_pkg::*;

  logic [DATA_W-1:0] fifo4_out, fifo5_out, fifo6_out, fifo7_out;
  logic              empty4, empty5, empty6, empty7;
  logic              pop4, pop5, pop6, pop7;

  // Stream handshake: a word moves on every rising edge where
  // valid_out && ready_in; data_out/src_out hold while valid_out && !ready_in.
  logic [DATA_W-1:0] data_out;
  logic [1:0]        src_out;
  logic              valid_out;
  logic              ready_in;

  modport master (
    output fifo4_out, fifo5_out, fifo6_out, fifo7_out,
    output empty4, empty5, empty6, empty7,
    output ready_in,
    input  pop4, pop5, pop6, pop7,
    input  data_out, src_out, valid_out
  );

  modport slave (
    input  fifo4_out, fifo5_out, fifo6_out, fifo7_out,
    input  empty4, empty5, empty6, empty7,
    input  ready_in,
    output pop4, pop5, pop6, pop7,
    output data_out, src_out, valid_out
  );

endinterface

// File: rtl/egress_queue.sv
// Circular output queue with an enqueue port and a valid/ready head.
// Head data reads as zero while the queue is empty.
module egress_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enq_valid,
  input  logic [W-1:0]               enq_data,
  input  logic                       deq_ready,
  output logic [W-1:0]               head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [OCC_W-1:0] occ_q;
  logic             enq, deq;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid = (occ_q != '0);
  assign head_data  = head_valid ? mem[head] : '0;
  assign occ        = occ_q;
  assign deq        = head_valid && deq_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign enq        = enq_valid && ((occ_q != OCC_W'(DEPTH)) || deq);

  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= enq_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      occ_q <= '0;
    end else begin
      if (enq) tail <= next_ptr(tail);
      if (deq) head <= next_ptr(head);
      case ({enq, deq})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/egress_scheduler.sv
// Drains FIFOs 4..7 round-robin into one valid/ready word stream, with
// credit-based popping so downstream stalls never lose a word.
module egress_scheduler
  import egress_scheduler_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  egress_scheduler_if.slave bus,
  input  logic              enable,
  input  logic [1:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              idle,
  output state_t            state_dbg
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;

  state_t                state;
  logic [1:0]            ptr;
  logic                  inflight;
  src_t                  inflight_src;
  logic [CNT_W-1:0]      cnt_q [NUM_PORTS];
  logic [NUM_PORTS-1:0]  empty_v;
  logic [DATA_W-1:0]     fifo_data [NUM_PORTS];
  logic [OCC_W-1:0]      occ;
  logic [DATA_W+1:0]     q_head;
  logic                  q_valid;
  logic                  credit_ok, gnt_found, do_pop;
  logic [1:0]            gnt_port, cand;

  assign empty_v      = {bus.empty7, bus.empty6, bus.empty5, bus.empty4};
  assign fifo_data[0] = bus.fifo4_out;
  assign fifo_data[1] = bus.fifo5_out;
  assign fifo_data[2] = bus.fifo6_out;
  assign fifo_data[3] = bus.fifo7_out;

  // Every popped word already owns a queue slot; same-cycle dequeues are not credited.
  assign credit_ok = ({1'b0, occ} + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH);

  always_comb begin
    gnt_found = 1'b0;
    gnt_port  = ptr;
    cand      = ptr;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = ptr + 2'(i);
      if (!gnt_found && !empty_v[cand]) begin
        gnt_found = 1'b1;
        gnt_port  = cand;
      end
    end
  end

  assign do_pop   = (state == ACTIVE) && gnt_found && credit_ok;
  assign bus.pop4 = do_pop && (gnt_port == 2'd0);
  assign bus.pop5 = do_pop && (gnt_port == 2'd1);
  assign bus.pop6 = do_pop && (gnt_port == 2'd2);
  assign bus.pop7 = do_pop && (gnt_port == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= 2'd3;
      inflight     <= 1'b0;
      inflight_src <= SRC_FIFO4;
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      case (state)
        IDLE:    if (enable) state <= ACTIVE;
        ACTIVE:  if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable) state <= ACTIVE;
          else if (!inflight && (occ == '0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      inflight <= do_pop;
      if (do_pop) begin
        ptr          <= gnt_port;
        inflight_src <= src_t'(gnt_port);
      end
      if (inflight) cnt_q[inflight_src] <= cnt_q[inflight_src] + CNT_W'(1);
    end
  end

  egress_queue #(
    .DEPTH (BUF_DEPTH),
    .W     (DATA_W + 2)
  ) u_queue (
    .clk        (clk),
    .rst_n      (reset),
    .enq_valid  (inflight),
    .enq_data   ({inflight_src, fifo_data[inflight_src]}),
    .deq_ready  (bus.ready_in),
    .head_data  (q_head),
    .head_valid (q_valid),
    .occ        (occ)
  );

  assign bus.data_out  = q_head[DATA_W-1:0];
  assign bus.src_out   = q_head[DATA_W+1:DATA_W];
  assign bus.valid_out = q_valid;
  assign cnt_out       = cnt_q[cnt_sel];
  assign idle          = (state == IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_egress_scheduler.sv
// Directed bench for egress_scheduler: FIFO models, an in-order word
// scoreboard with round-robin/credit model, and per-test literal checks.
module tb_egress_scheduler;
  import egress_scheduler_pkg::*;

  localparam int BUF_DEPTH = 4;
  localparam int CNT_W     = 8;
  localparam int EW        = 32 + 2 + DATA_W;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             ready = 1'b1;
  logic [1:0]       cnt_sel = 2'd0;
  logic [CNT_W-1:0] cnt_out;
  logic             idle;
  state_t           state_dbg;
  int               cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  egress_scheduler_if bus();

  egress_scheduler #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .enable    (enable),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out),
    .idle      (idle),
    .state_dbg (state_dbg)
  );

  // ---------------- upstream FIFO models ----------------
  logic [DATA_W-1:0] fq [4][$];
  logic [DATA_W-1:0] fdata [4] = '{default: '0};
  logic [3:0]        fempty = 4'hF;
  logic [3:0]        pend = 4'h0;
  logic [3:0]        pops;

  assign bus.fifo4_out = fdata[0];
  assign bus.fifo5_out = fdata[1];
  assign bus.fifo6_out = fdata[2];
  assign bus.fifo7_out = fdata[3];
  assign bus.empty4    = fempty[0];
  assign bus.empty5    = fempty[1];
  assign bus.empty6    = fempty[2];
  assign bus.empty7    = fempty[3];
  assign bus.ready_in  = ready;
  assign pops          = {bus.pop7, bus.pop6, bus.pop5, bus.pop4};

  // Registered read data and empty flags, updated just after the edge.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 4; p++) begin
      if (pend[p] && fq[p].size() > 0) fdata[p] = fq[p].pop_front();
      fempty[p] = (fq[p].size() == 0);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [EW-1:0]     exp_q[$];
  int                last_gnt = 3;
  logic              en_seen;
  logic [CNT_W-1:0]  mcnt [4] = '{default: '0};
  int                pop_log[$], pop_cyc[$], del_cyc[$];
  logic [DATA_W-1:0] del_data[$];
  logic [1:0]        del_src[$];
  int                first_valid = -1;

  // The scheduler is popping exactly when the previous edge saw enable=1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_seen <= 1'b0;
    else        en_seen <= enable;
  end

  function automatic int rr_pick(input int last, input logic [3:0] fe);
    for (int i = 1; i <= 4; i++) begin
      int idx = (last + i) % 4;
      if (!fe[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_gnt = 3;
      pend     = 4'h0;
      for (int p = 0; p < 4; p++) mcnt[p] = '0;
    end else begin
      logic          exp_any, exp_valid;
      int            act_p, exp_p, hc;
      logic [EW-1:0] head;
      pend    = pops;
      exp_any = en_seen && (fempty != 4'hF) && (exp_q.size() < BUF_DEPTH);
      check("pop_any", |pops, exp_any);
      if (|pops) begin
        act_p = 0;
        for (int i = 0; i < 4; i++) if (pops[i]) act_p = i;
        exp_p = rr_pick(last_gnt, fempty);
        check("pop_onehot", $onehot(pops), 1'b1);
        check("pop_nonempty", fempty[act_p], 1'b0);
        check("grant", pops, 4'b0001 << exp_p);
        pop_log.push_back(act_p);
        pop_cyc.push_back(cyc);
        if (fq[act_p].size() > 0) exp_q.push_back({32'(cyc), 2'(act_p), fq[act_p][0]});
        last_gnt = act_p;
      end
      check("occupancy", exp_q.size() <= BUF_DEPTH, 1'b1);
      exp_valid = 1'b0;
      head      = '0;
      if (exp_q.size() > 0) begin
        head      = exp_q[0];
        hc        = int'(head[EW-1 -: 32]);
        exp_valid = (hc + 2 <= cyc);
      end
      check("valid_out", bus.valid_out, exp_valid);
      if (bus.valid_out && first_valid < 0) first_valid = cyc;
      if (bus.valid_out && exp_valid) begin
        check("data_out", bus.data_out, head[DATA_W-1:0]);
        check("src_out", bus.src_out, head[DATA_W+1:DATA_W]);
        if (ready) begin
          del_data.push_back(bus.data_out);
          del_src.push_back(bus.src_out);
          del_cyc.push_back(cyc);
          mcnt[head[DATA_W+1:DATA_W]] = mcnt[head[DATA_W+1:DATA_W]] + CNT_W'(1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int p, input logic [DATA_W-1:0] w);
    fq[p].push_back(w);
  endtask

  task automatic clear_logs();
    pop_log.delete(); pop_cyc.delete(); del_cyc.delete();
    del_data.delete(); del_src.delete();
    first_valid = -1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_deliv(input int n, input int budget, input string name);
    int k = 0;
    while (del_data.size() < n && k < budget) begin tick(); k++; end
    check(name, del_data.size(), n);
  endtask

  task automatic check_cnt(input logic [1:0] sel, input logic [CNT_W-1:0] exp, input string name);
    cnt_sel = sel;
    #1;
    check(name, cnt_out, exp);
  endtask

  logic [DATA_W-1:0] t2_data [8] = '{10'h040, 10'h080, 10'h0C0, 10'h100,
                                     10'h041, 10'h081, 10'h0C1, 10'h101};
  logic [1:0]        t2_src  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

  // ---------------- directed tests ----------------
  initial begin
    int k;
    #3;
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_pops", pops, 4'h0);
    check("rst_data", bus.data_out, '0);
    check("rst_src", bus.src_out, 2'd0);
    check("rst_idle", idle, 1'b1);
    check("rst_state", state_dbg, IDLE);
    for (int s = 0; s < 4; s++) check_cnt(2'(s), '0, "rst_cnt");
    tick();
    rst_n = 1'b1;

    // 1: single port, three words
    clear_logs();
    push(0, 10'h101); push(0, 10'h102); push(0, 10'h103);
    enable = 1'b1;
    wait_deliv(3, 30, "t1_deliv");
    check("t1_pops", pop_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t1_pop_port", pop_log[i], 0);
      check("t1_pop_consec", pop_cyc[i] - pop_cyc[0], i);
      check("t1_data", del_data[i], 10'h101 + 10'(i));
      check("t1_src", del_src[i], 2'd0);
    end
    check("t1_latency", first_valid - pop_cyc[0], 2);
    check_cnt(2'd0, 8'd3, "t1_cnt0");

    // 2: all ports, two words each, fresh pointer
    do_reset();
    clear_logs();
    for (int w = 0; w < 2; w++)
      for (int p = 0; p < 4; p++) push(p, 10'h040 * 10'(p + 1) + 10'(w));
    wait_deliv(8, 40, "t2_deliv");
    for (int i = 0; i < 8; i++) begin
      check("t2_grant", pop_log[i], int'(t2_src[i]));
      check("t2_src", del_src[i], t2_src[i]);
      check("t2_data", del_data[i], t2_data[i]);
    end
    check("t2_back_to_back", del_cyc[7] - del_cyc[0], 7);

    // 3: backpressure fills the queue, then resumes
    clear_logs();
    ready = 1'b0;
    for (int w = 0; w < 6; w++) push(1, 10'h2A0 + 10'(w));
    repeat (12) tick();
    check("t3_pops_stalled", pop_log.size(), BUF_DEPTH);
    check("t3_valid", bus.valid_out, 1'b1);
    check("t3_head", bus.data_out, 10'h2A0);
    check("t3_head_src", bus.src_out, 2'd1);
    ready = 1'b1;
    wait_deliv(6, 40, "t3_deliv");
    for (int i = 0; i < 6; i++) check("t3_data", del_data[i], 10'h2A0 + 10'(i));
    check("t3_pops_total", pop_log.size(), 6);

    // 4: enable dropped with 3 queued and 1 in flight
    clear_logs();
    ready = 1'b0;
    for (int w = 0; w < 6; w++) push(2, 10'h3B0 + 10'(w));
    k = 0;
    while (pop_log.size() < 4 && k < 20) begin tick(); k++; end
    check("t4_fill", pop_log.size(), 4);
    enable = 1'b0;
    ready  = 1'b1;
    wait_deliv(4, 20, "t4_drain_deliv");
    k = 0;
    while (!idle && k < 20) begin tick(); k++; end
    check("t4_idle", idle, 1'b1);
    check("t4_no_pops", pop_log.size(), 4);
    check("t4_empty", bus.valid_out, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    check("t4_pop_wait", bus.pop6, 1'b0);
    @(negedge clk);
    check("t4_pop_resume", bus.pop6, 1'b1);
    wait_deliv(6, 20, "t4_deliv");
    for (int i = 0; i < 6; i++) check("t4_data", del_data[i], 10'h3B0 + 10'(i));

    // 5: reset mid-stream with two words queued
    clear_logs();
    ready = 1'b0;
    push(1, 10'h1E0); push(1, 10'h1E1);
    k = 0;
    while (pop_log.size() < 2 && k < 20) begin tick(); k++; end
    tick();
    check("t5_queued", bus.valid_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_valid", bus.valid_out, 1'b0);
    check("t5_pops", pops, 4'h0);
    check("t5_data", bus.data_out, '0);
    check("t5_idle", idle, 1'b1);
    for (int s = 0; s < 4; s++) check_cnt(2'(s), '0, "t5_cnt");
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    clear_logs();
    push(0, 10'h011); push(1, 10'h022); push(2, 10'h033); push(3, 10'h044);
    wait_deliv(4, 30, "t5_deliv");
    check("t5_first_grant", pop_log[0], 0);
    check("t5_first_data", del_data[0], 10'h011);

    // 6: counter wrap on fifo6
    do_reset();
    clear_logs();
    for (int w = 0; w < 256; w++) push(2, 10'(w * 3));
    wait_deliv(256, 700, "t6_deliv");
    check_cnt(2'd2, 8'd0, "t6_wrap");
    check("t6_model", cnt_out, mcnt[2]);
    check_cnt(2'd0, 8'd0, "t6_other");
    push(2, 10'h3FF);
    wait_deliv(257, 20, "t6_deliv_257");
    check_cnt(2'd2, 8'd1, "t6_after_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
